// File: rtl/regfile_write_sequencer.sv
// regfile_write_sequencer: buffers writebacks and replays them as setup/strobe/hold writes with read forwarding
module regfile_write_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [4:0]       wb_reg,
  input  logic [31:0]      wb_data,
  output logic             rf_write,
  output logic [4:0]       rf_reg_no,
  output logic [31:0]      rf_data,
  input  logic [4:0]       rd_reg1,
  input  logic [4:0]       rd_reg2,
  input  logic [31:0]      rf_read_data1,
  input  logic [31:0]      rf_read_data2,
  output logic [31:0]      rd_data1,
  output logic [31:0]      rd_data2,
  output logic [CNT_W-1:0] pending_count,
  output logic             idle
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t state, state_nx;
  logic [4:0]    mem_reg  [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, ld_ptr, fi;
  logic          push, pop, load;
  assign wb_ready = pending_count < CNT_W'(DEPTH);
  assign push     = wb_valid && wb_ready;
  assign pop      = state == HOLD;
  assign load     = (state == IDLE && pending_count != '0) || (pop && pending_count > CNT_W'(1));
  assign ld_ptr   = pop ? rd_ptr + PW'(1) : rd_ptr;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;
  always_comb
    state_nx = state == IDLE   ? (pending_count != '0 ? SETUP : IDLE) :
               state == SETUP  ? STROBE :
               state == STROBE ? HOLD :
               (pending_count > CNT_W'(1) ? SETUP : IDLE);
  always_comb begin
    rf_write = state == STROBE;
    idle     = pending_count == '0 && state == IDLE;
  end
  always_ff @(posedge clk)
    if (push) begin
      mem_reg[wr_ptr]  <= wb_reg;
      mem_data[wr_ptr] <= wb_data;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      pending_count <= '0;
      rf_reg_no     <= '0;
      rf_data       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      pending_count <= pending_count + CNT_W'(push) - CNT_W'(pop);
      if (load) begin
        rf_reg_no <= mem_reg[ld_ptr];
        rf_data   <= mem_data[ld_ptr];
      end
    end
  // oldest-to-newest scan so the newest matching entry wins
  always_comb begin
    rd_data1 = rf_read_data1;
    rd_data2 = rf_read_data2;
    fi       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fi = rd_ptr + PW'(i);
      if (i < int'(pending_count)) begin
        if (mem_reg[fi] == rd_reg1) rd_data1 = mem_data[fi];
        if (mem_reg[fi] == rd_reg2) rd_data2 = mem_data[fi];
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_sequencer.sv
// tb_regfile_write_sequencer: vector table, directed corner cases and random traffic against a queue model
module tb_regfile_write_sequencer;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 1, wb_valid = 0, wb_ready, rf_write, idle;
  logic [4:0] wb_reg = 0, rf_reg_no, rd_reg1 = 0, rd_reg2 = 0;
  logic [31:0] wb_data = 0, rf_data, rf_read_data1 = 0, rf_read_data2 = 0, rd_data1, rd_data2;
  logic [2:0] pending_count;
  regfile_write_sequencer #(.DEPTH(DEPTH), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg),
    .wb_data(wb_data), .rf_write(rf_write), .rf_reg_no(rf_reg_no), .rf_data(rf_data),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .rf_read_data1(rf_read_data1),
    .rf_read_data2(rf_read_data2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .pending_count(pending_count), .idle(idle));
  always #5 clk = ~clk;
  typedef struct {logic [4:0] r; logic [31:0] d;} ent_t;
  typedef struct {
    bit v; logic [4:0] r; logic [31:0] d;
    bit ew; logic [4:0] er; logic [31:0] ed; logic [2:0] ec; bit erdy; bit ei;
  } vec_t;
  ent_t q[$];
  int strobe_cyc[$];
  logic [31:0] dut_rf [32];
  int npass = 0, nchk = 0, cyc = 0, pop_cd = 0;
  bit last_push, chk_en = 0;
  vec_t cur;
  vec_t tv [7];
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", n, got, exp, cyc);
  endtask
  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] dflt);
    logic [31:0] v = dflt;
    foreach (q[i]) if (q[i].r == r) v = q[i].d;
    return v;
  endfunction
  task automatic check_model();
    chk("count", 32'(pending_count), 32'(q.size()));
    chk("ready", 32'(wb_ready), 32'(q.size() < DEPTH));
    chk("idle", 32'(idle), 32'(q.size() == 0));
    chk("fwd1", rd_data1, fwd(rd_reg1, rf_read_data1));
    chk("fwd2", rd_data2, fwd(rd_reg2, rf_read_data2));
    if (rf_write) begin
      if (q.size() == 0 || pop_cd != 0) chk("unexpected_strobe", 32'(rf_write), 32'(0));
      else begin
        chk("strobe_reg", 32'(rf_reg_no), 32'(q[0].r));
        chk("strobe_data", rf_data, q[0].d);
        dut_rf[rf_reg_no] = rf_data;
        strobe_cyc.push_back(cyc);
        pop_cd = 2;
      end
    end
  endtask
  task automatic cycle();
    @(negedge clk);
    check_model();
    if (chk_en) begin
      chk("vec_write", 32'(rf_write), 32'(cur.ew));
      chk("vec_reg", 32'(rf_reg_no), 32'(cur.er));
      chk("vec_data", rf_data, cur.ed);
      chk("vec_count", 32'(pending_count), 32'(cur.ec));
      chk("vec_ready", 32'(wb_ready), 32'(cur.erdy));
      chk("vec_idle", 32'(idle), 32'(cur.ei));
    end
    @(posedge clk);
    last_push = wb_valid && q.size() < DEPTH;
    if (pop_cd > 0) begin
      pop_cd--;
      if (pop_cd == 0) void'(q.pop_front());
    end
    if (last_push) q.push_back('{wb_reg, wb_data});
    cyc++;
    #1;
  endtask
  task automatic push(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1; wb_reg = r; wb_data = d;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (last_push) break;
    end
    if (!last_push) chk("push_timeout", 0, 1);
    wb_valid = 0;
  endtask
  task automatic drain();
    bit done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      if (q.size() == 0 && pop_cd == 0 && idle) done = 1;
      else cycle();
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int n0;
    bit seen;
    foreach (dut_rf[i]) dut_rf[i] = 0;
    tv[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1, 1};
    tv[1] = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
    tv[2] = '{0, 0, 0, 0, 5, 32'hDEADBEEF, 1, 1, 0};
    tv[3] = '{0, 0, 0, 1, 5, 32'hDEADBEEF, 1, 1, 0};
    tv[4] = '{0, 0, 0, 0, 5, 32'hDEADBEEF, 1, 1, 0};
    tv[5] = '{0, 0, 0, 0, 5, 32'hDEADBEEF, 0, 1, 1};
    tv[6] = '{0, 0, 0, 0, 5, 32'hDEADBEEF, 0, 1, 1};
    #12;
    chk("rst_write", 32'(rf_write), 0);
    chk("rst_count", 32'(pending_count), 0);
    chk("rst_ready", 32'(wb_ready), 1);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_reg", 32'(rf_reg_no), 0);
    chk("rst_data", rf_data, 0);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    // single write, cycle-exact
    chk_en = 1;
    foreach (tv[i]) begin
      cur = tv[i];
      wb_valid = cur.v; wb_reg = cur.r; wb_data = cur.d;
      cycle();
    end
    chk_en = 0;
    wb_valid = 0;
    // back-to-back fill: fifth request waits for the first pop, strobes every 3 cycles
    n0 = strobe_cyc.size();
    for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + i);
    chk("full_ready", 32'(wb_ready), 0);
    chk("full_count", 32'(pending_count), 4);
    push(5, 32'h105);
    drain();
    chk("fill_strobes", 32'(strobe_cyc.size() - n0), 5);
    for (int i = n0 + 1; i < strobe_cyc.size(); i++) chk("strobe_gap", 32'(strobe_cyc[i] - strobe_cyc[i-1]), 3);
    for (int i = 1; i <= 5; i++) chk("fill_rf", dut_rf[i], 32'h100 + i);
    // forwarding of the newest pending entry
    rd_reg1 = 7; rf_read_data1 = 0; rd_reg2 = 8; rf_read_data2 = 32'h55;
    push(7, 32'h11);
    chk("fwd_first", rd_data1, 32'h11);
    push(7, 32'h22);
    chk("fwd_newest", rd_data1, 32'h22);
    chk("fwd_other", rd_data2, 32'h55);
    drain();
    chk("fwd_after", rd_data1, 0);
    // same-register ordering
    push(3, 32'hA);
    push(3, 32'hB);
    drain();
    chk("last_wins", dut_rf[3], 32'hB);
    // simultaneous push and pop while not full
    push(10, 32'hC0);
    push(11, 32'hC1);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (rf_write) seen = 1;
      else cycle();
    end
    chk("pp_strobe_seen", 32'(seen), 1);
    cycle();
    chk("pp_hold_count", 32'(pending_count), 2);
    push(12, 32'hC2);
    chk("pp_after_count", 32'(pending_count), 2);
    drain();
    chk("pp_rf12", dut_rf[12], 32'hC2);
    chk("pp_order", 32'(strobe_cyc[strobe_cyc.size()-1] - strobe_cyc[strobe_cyc.size()-2]), 3);
    // reset in the middle of a strobe
    push(20, 32'hE0);
    push(21, 32'hE1);
    push(22, 32'hE2);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (rf_write) seen = 1;
      else cycle();
    end
    chk("mid_strobe_seen", 32'(seen), 1);
    chk("mid_count", 32'(pending_count), 3);
    #2 reset = 1;
    #1;
    chk("mid_rst_write", 32'(rf_write), 0);
    chk("mid_rst_count", 32'(pending_count), 0);
    chk("mid_rst_idle", 32'(idle), 1);
    chk("mid_rst_ready", 32'(wb_ready), 1);
    q.delete();
    pop_cd = 0;
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) cycle();
    // random traffic
    for (int k = 0; k < 400; k++) begin
      wb_valid = $urandom_range(0, 1) == 1;
      wb_reg = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      rd_reg1 = 5'($urandom_range(0, 7));
      rd_reg2 = 5'($urandom_range(0, 7));
      rf_read_data1 = $urandom;
      rf_read_data2 = $urandom;
      cycle();
    end
    wb_valid = 0;
    drain();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
